// File: rtl/pipe_ctrl_pkg.sv
// Shared Y86 encodings for the pipeline control slice: icodes, register
// sentinel, status codes and the control FSM state type.
package pipe_ctrl_pkg;

    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] NREG    = 4'hF;

    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SHLT    = 3'd2;
    localparam logic [2:0] SADR    = 3'd3;
    localparam logic [2:0] SINS    = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-information and stall/bubble bundle between the pipeline registers
// (master) and the pipeline control unit (slave).
interface pipe_ctrl_if #(
    parameter int unsigned ICODE_W = 4,
    parameter int unsigned REG_W   = 4,
    parameter int unsigned STAT_W  = 3
);
    logic [ICODE_W-1:0] D_icode;
    logic [REG_W-1:0]   d_srcA;
    logic [REG_W-1:0]   d_srcB;
    logic [ICODE_W-1:0] E_icode;
    logic [REG_W-1:0]   E_dstM;
    logic               e_Cnd;
    logic [ICODE_W-1:0] M_icode;
    logic [STAT_W-1:0]  m_stat;
    logic [STAT_W-1:0]  W_stat;

    logic F_stall;
    logic D_stall;
    logic D_bubble;
    logic E_stall;
    logic E_bubble;
    logic M_stall;
    logic M_bubble;
    logic W_stall;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall
    );
endinterface

// File: rtl/pipe_ctrl_perf_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86 five-stage pipeline control: stall/bubble generation from hazards,
// run/hold/halted debug FSM and saturating performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned ICODE_W = 4,
    parameter int unsigned REG_W   = 4,
    parameter int unsigned STAT_W  = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    pipe_ctrl_if.slave       pif,
    input  logic             hold_i,
    input  logic             step_i,
    input  logic             cnt_clr_i,
    output logic             halted_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cyc_cnt_o,
    output logic [CNT_W-1:0] lu_cnt_o,
    output logic [CNT_W-1:0] mis_cnt_o,
    output logic [CNT_W-1:0] ret_cnt_o
);

    state_e state_q;
    state_e state_d;

    logic lu;
    logic ret;
    logic mis;
    logic mexc;
    logic wexc;
    logic advancing;

    always_comb begin
        lu   = ((pif.E_icode == ICODE_W'(IMRMOVQ)) || (pif.E_icode == ICODE_W'(IPOPQ)))
            && (pif.E_dstM != REG_W'(NREG))
            && ((pif.E_dstM == pif.d_srcA) || (pif.E_dstM == pif.d_srcB));
        ret  = (pif.D_icode == ICODE_W'(IRET)) || (pif.E_icode == ICODE_W'(IRET))
            || (pif.M_icode == ICODE_W'(IRET));
        mis  = (pif.E_icode == ICODE_W'(IJXX)) && !pif.e_Cnd;
        mexc = (pif.m_stat == STAT_W'(SADR)) || (pif.m_stat == STAT_W'(SINS))
            || (pif.m_stat == STAT_W'(SHLT));
        wexc = (pif.W_stat == STAT_W'(SADR)) || (pif.W_stat == STAT_W'(SINS))
            || (pif.W_stat == STAT_W'(SHLT));
    end

    assign advancing = (state_q == ST_RUN) || ((state_q == ST_HOLD) && step_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if ((state_q != ST_HALTED) && advancing && wexc) begin
            state_d = ST_HALTED;
        end else if ((state_q == ST_RUN) && hold_i) begin
            state_d = ST_HOLD;
        end else if ((state_q == ST_HOLD) && !hold_i) begin
            state_d = ST_RUN;
        end
    end

    // Frozen (hold without step, or halted) stalls every register and injects nothing.
    always_comb begin
        pif.F_stall  = 1'b1;
        pif.D_stall  = 1'b1;
        pif.D_bubble = 1'b0;
        pif.E_stall  = 1'b1;
        pif.E_bubble = 1'b0;
        pif.M_stall  = 1'b1;
        pif.M_bubble = 1'b0;
        pif.W_stall  = 1'b1;
        if (advancing) begin
            pif.F_stall  = lu | ret;
            pif.D_stall  = lu;
            pif.D_bubble = mis | (!lu & ret);
            pif.E_stall  = 1'b0;
            pif.E_bubble = mis | lu;
            pif.M_stall  = 1'b0;
            pif.M_bubble = mexc | wexc;
            pif.W_stall  = wexc;
        end
    end

    assign halted_o = (state_q == ST_HALTED);
    assign state_o  = state_q;

    perf_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .inc_i  (state_q != ST_HALTED),
        .clr_i  (cnt_clr_i),
        .cnt_o  (cyc_cnt_o)
    );

    perf_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .inc_i  (advancing && lu),
        .clr_i  (cnt_clr_i),
        .cnt_o  (lu_cnt_o)
    );

    perf_counter #(.CNT_W(CNT_W)) u_mis_cnt (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .inc_i  (advancing && mis),
        .clr_i  (cnt_clr_i),
        .cnt_o  (mis_cnt_o)
    );

    perf_counter #(.CNT_W(CNT_W)) u_ret_cnt (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .inc_i  (advancing && ret),
        .clr_i  (cnt_clr_i),
        .cnt_o  (ret_cnt_o)
    );

endmodule
